// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

    localparam int LSU_ADDR_W      = 16;
    localparam int LSU_DATA_W      = 16;
    localparam int LSU_TIMEOUT_CYC = 64;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Access watchdog: counts ACCESS cycles and flags when TIMEOUT_CYC-1 is reached.
module lsu_timeout_ctr
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack handshake with data memory, pipeline stall and MEM/WB bubble.
// Optional alignment trap enabled by defining LSU_ALIGN_CHECK_EN.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = LSU_ADDR_W,
    parameter int DATA_W      = LSU_DATA_W,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              memRead_m,
    input  logic              memWrite_m,
    input  logic [ADDR_W-1:0] aluRes_m,
    input  logic [DATA_W-1:0] writeData_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [DATA_W-1:0] readData_o,
    output logic              bus_err_o,
    output logic              misalign_o
);

    lsu_state_t state;
    logic       acc;
    logic       expired;

    assign acc = valid_m & (memRead_m | memWrite_m);

    lsu_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == IDLE) & acc),
        .enable (state == ACCESS),
        .expired(expired)
    );

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Ack wins over timeout; dmem_we doubles as the load/store flag of the outstanding access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            readData_o <= '0;
            bus_err_o  <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            bus_err_o <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (acc) begin
`ifdef LSU_ALIGN_CHECK_EN
                        if (aluRes_m[0]) begin
                            misalign_q <= 1'b1;
                            readData_o <= '0;
                            state      <= DONE;
                        end else begin
                            dmem_addr  <= aluRes_m;
                            dmem_wdata <= writeData_m;
                            dmem_we    <= memWrite_m;
                            dmem_req   <= 1'b1;
                            state      <= ACCESS;
                        end
`else
                        dmem_addr  <= aluRes_m;
                        dmem_wdata <= writeData_m;
                        dmem_we    <= memWrite_m;
                        dmem_req   <= 1'b1;
                        state      <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            readData_o <= dmem_rdata;
                        end
                        state <= DONE;
                    end else if (expired) begin
                        dmem_req   <= 1'b0;
                        readData_o <= '0;
                        bus_err_o  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o  = ((state == IDLE) & acc) | (state == ACCESS);
    assign bubble_o = stall_o;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (TIMEOUT_CYC = 8); expected load results are queued per access.
module tb_mem_stage_lsu;

    typedef struct {
        logic [15:0] rdata;
        int          err;
        int          mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_m = 1'b0;
    logic        memRead_m = 1'b0;
    logic        memWrite_m = 1'b0;
    logic [15:0] aluRes_m = '0;
    logic [15:0] writeData_m = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic        stall_o;
    logic        bubble_o;
    logic [15:0] readData_o;
    logic        bus_err_o;
    logic        misalign_o;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    // per-access observations
    int          r_stall, r_req, r_err, r_mis;
    bit          r_stable, r_bubble_ok;
    logic [15:0] r_addr, r_wdata, r_rd;
    logic        r_we;

    mem_stage_lsu #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_m    (valid_m),
        .memRead_m  (memRead_m),
        .memWrite_m (memWrite_m),
        .aluRes_m   (aluRes_m),
        .writeData_m(writeData_m),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall_o    (stall_o),
        .bubble_o   (bubble_o),
        .readData_o (readData_o),
        .bus_err_o  (bus_err_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    // Presents one instruction and follows it until the DONE cycle (stall low); returns at that cycle's negedge.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata, input int waits);
        bit done;
        done = 0;
        r_stall = 0; r_req = 0; r_err = 0; r_mis = 0;
        r_stable = 1; r_bubble_ok = 1;
        r_addr = '0; r_wdata = '0; r_we = 1'b0; r_rd = '0;
        @(posedge clk); #1;
        valid_m = 1'b1; memRead_m = rd; memWrite_m = wr;
        aluRes_m = addr; writeData_m = wdata;
        dmem_ack = 1'b0; dmem_rdata = rdata;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (bubble_o !== stall_o) r_bubble_ok = 0;
            if (bus_err_o === 1'b1) r_err++;
            if (misalign_o === 1'b1) r_mis++;
            if (dmem_req === 1'b1) begin
                if (r_req == 0) begin
                    r_addr = dmem_addr; r_we = dmem_we; r_wdata = dmem_wdata;
                end else if (dmem_addr !== r_addr || dmem_we !== r_we || dmem_wdata !== r_wdata) begin
                    r_stable = 0;
                end
                r_req++;
            end
            if (stall_o === 1'b1) begin
                r_stall++;
            end else begin
                done = 1;
                r_rd = readData_o;
            end
            if (!done) begin
                @(posedge clk); #1;
                dmem_ack = (dmem_req === 1'b1) && (waits >= 0) && (r_req == waits);
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL access_done: access at %h still stalled after 400 cycles, required completion", addr);
        end
    endtask

    task automatic end_instr();
        @(posedge clk); #1;
        valid_m = 1'b0; memRead_m = 1'b0; memWrite_m = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({dmem_req, dmem_we, bus_err_o, misalign_o, stall_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: req/we/err/mis/stall=%b required 00000",
                     {dmem_req, dmem_we, bus_err_o, misalign_o, stall_o});
        end
        vectors++;
        if (dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0000 0000", dmem_addr, dmem_wdata);
        end
        vectors++;
        if (readData_o !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h required 0000", readData_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_o !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: stall=%b req=%b required 0 0", stall_o, dmem_req);
        end
    endtask

    task automatic test_load();
        sb.push_back('{16'hBEEF, 0, 0});
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
        e = sb.pop_front();
        vectors++;
        if (r_req != 1 || r_we !== 1'b0 || r_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL load_req: req_cycles=%0d we=%b addr=%h required 1 0 0040", r_req, r_we, r_addr);
        end
        vectors++;
        if (r_stall != 2 || !r_bubble_ok) begin
            miscompares++;
            $display("FAIL load_stall: stall_cycles=%0d bubble_ok=%0d required 2 1", r_stall, r_bubble_ok);
        end
        vectors++;
        if (r_rd !== e.rdata || r_err != e.err) begin
            miscompares++;
            $display("FAIL load_data: rdata=%h err=%0d required %h %0d", r_rd, r_err, e.rdata, e.err);
        end
        end_instr();
    endtask

    task automatic test_store();
        sb.push_back('{16'hBEEF, 0, 0});
        do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 16'hDEAD, 3);
        e = sb.pop_front();
        vectors++;
        if (r_req != 4 || !r_stable || r_we !== 1'b1 || r_wdata !== 16'h1234 || r_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL store_req: req_cycles=%0d stable=%0d we=%b wdata=%h addr=%h required 4 1 1 1234 0010",
                     r_req, r_stable, r_we, r_wdata, r_addr);
        end
        vectors++;
        if (r_stall != 5) begin
            miscompares++;
            $display("FAIL store_stall: stall_cycles=%0d required 5", r_stall);
        end
        vectors++;
        if (r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL store_rdata_hold: rdata=%h required %h", r_rd, e.rdata);
        end
        end_instr();
    endtask

    task automatic test_alu();
        bit quiet;
        quiet = 1;
        @(posedge clk); #1;
        valid_m = 1'b1; memRead_m = 1'b0; memWrite_m = 1'b0; aluRes_m = 16'h0044;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stall_o !== 1'b0 || dmem_req !== 1'b0 || bubble_o !== 1'b0) quiet = 0;
            @(posedge clk); #1;
            aluRes_m = aluRes_m + 16'd2;
        end
        vectors++;
        if (!quiet || readData_o !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL alu_passthru: quiet=%0d rdata=%h required 1 BEEF", quiet, readData_o);
        end
        end_instr();
    endtask

    task automatic test_timeout();
        sb.push_back('{16'h0000, 1, 0});
        do_access(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, -1);
        e = sb.pop_front();
        vectors++;
        if (r_req != 8 || r_stall != 9 || !r_stable) begin
            miscompares++;
            $display("FAIL timeout_len: req_cycles=%0d stall_cycles=%0d stable=%0d required 8 9 1",
                     r_req, r_stall, r_stable);
        end
        vectors++;
        if (r_err != e.err || r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL timeout_err: err_pulses=%0d rdata=%h required %0d %h", r_err, r_rd, e.err, e.rdata);
        end
        // late ack during DONE and the following IDLE
        dmem_ack = 1'b1; dmem_rdata = 16'hAAAA;
        @(posedge clk); #1;
        valid_m = 1'b0; memRead_m = 1'b0;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b0 || stall_o !== 1'b0 || readData_o !== 16'h0 || bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack: req=%b stall=%b rdata=%h err=%b required 0 0 0000 0",
                     dmem_req, stall_o, readData_o, bus_err_o);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        valid_m = 1'b1; memRead_m = 1'b1; aluRes_m = 16'h0300; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_access_req: req=%b required 1", dmem_req);
        end
        reset = 1'b1; valid_m = 1'b0; memRead_m = 1'b0;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: req=%b stall=%b required 0 0", dmem_req, stall_o);
        end
        @(posedge clk); #1;
        reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 16'h9999;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b0 || stall_o !== 1'b0 || readData_o !== 16'h0) begin
            miscompares++;
            $display("FAIL stray_ack: req=%b stall=%b rdata=%h required 0 0 0000", dmem_req, stall_o, readData_o);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        sb.push_back('{16'h5A5A, 0, 0});
        do_access(1'b1, 1'b0, 16'h0302, 16'h0000, 16'h5A5A, 1);
        e = sb.pop_front();
        vectors++;
        if (r_stall != 3 || r_req != 2 || r_rd !== e.rdata || r_addr !== 16'h0302) begin
            miscompares++;
            $display("FAIL load_after_reset: stall=%0d req=%0d rdata=%h addr=%h required 3 2 %h 0302",
                     r_stall, r_req, r_rd, r_addr, e.rdata);
        end
        end_instr();
    endtask

    task automatic test_odd_address();
`ifdef LSU_ALIGN_CHECK_EN
        sb.push_back('{16'h0000, 0, 1});
        do_access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h7777, 0);
        e = sb.pop_front();
        vectors++;
        if (r_req != 0 || r_stall != 1 || r_mis != e.mis || r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL misalign: req=%0d stall=%0d mis=%0d rdata=%h required 0 1 %0d %h",
                     r_req, r_stall, r_mis, r_rd, e.mis, e.rdata);
        end
`else
        sb.push_back('{16'h7777, 0, 0});
        do_access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h7777, 0);
        e = sb.pop_front();
        vectors++;
        if (r_req != 1 || r_addr !== 16'h0041 || r_stall != 2 || r_mis != e.mis || r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL odd_addr: req=%0d addr=%h stall=%0d mis=%0d rdata=%h required 1 0041 2 %0d %h",
                     r_req, r_addr, r_stall, r_mis, r_rd, e.mis, e.rdata);
        end
`endif
        end_instr();
    endtask

    task automatic test_back_to_back();
        sb.push_back('{16'h1111, 0, 0});
        sb.push_back('{16'h1111, 0, 0});
        do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1);
        e = sb.pop_front();
        vectors++;
        if (r_stall != 3 || r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL b2b_load: stall=%0d rdata=%h required 3 %h", r_stall, r_rd, e.rdata);
        end
        do_access(1'b0, 1'b1, 16'h0102, 16'h2222, 16'hFFFF, 0);
        e = sb.pop_front();
        vectors++;
        if (r_stall != 2 || r_req != 1 || r_we !== 1'b1 || r_wdata !== 16'h2222 || r_rd !== e.rdata) begin
            miscompares++;
            $display("FAIL b2b_store: stall=%0d req=%0d we=%b wdata=%h rdata=%h required 2 1 1 2222 %h",
                     r_stall, r_req, r_we, r_wdata, r_rd, e.rdata);
        end
        end_instr();
    endtask

    task automatic test_random_loads();
        int          w;
        logic [15:0] d, a;
        for (int i = 0; i < 6; i++) begin
            w = int'($urandom_range(0, 5));
            d = 16'($urandom);
            a = 16'($urandom) & 16'hFFFE;
            sb.push_back('{d, 0, 0});
            do_access(1'b1, 1'b0, a, 16'h0000, d, w);
            e = sb.pop_front();
            vectors++;
            if (r_stall != w + 2 || r_req != w + 1 || r_addr !== a || r_rd !== e.rdata || r_err != 0) begin
                miscompares++;
                $display("FAIL rand_load%0d: stall=%0d req=%0d addr=%h rdata=%h err=%0d required %0d %0d %h %h 0",
                         i, r_stall, r_req, r_addr, r_rd, r_err, w + 2, w + 1, a, e.rdata);
            end
            end_instr();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_timeout();
        test_reset_mid_access();
        test_odd_address();
        test_back_to_back();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM access (address = ALU result, store data, read/write controls) and runs a req/ack handshake with data memory.
- Stalls the front of the pipeline until the access completes.
- Presents load data and a bubble control to MEM/WB.

Parameters:
- ADDR_W, 16, data-memory address width (byte address).
- DATA_W, 16, data width.
- TIMEOUT_CYC, 64, ACCESS cycles without ack before a bus error is declared (range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- valid_m  in  1  EX/MEM slot holds a real instruction
- memRead_m  in  1  load
- memWrite_m  in  1  store (memRead_m and memWrite_m are never both 1)
- aluRes_m  in  ADDR_W  access address
- writeData_m  in  DATA_W  store data
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  ADDR_W  registered address
- dmem_wdata  out  DATA_W  registered store data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  DATA_W  valid when dmem_ack = 1
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- bubble_o  out  1  top level forces MEM/WB regWrite_in to 0
- readData_o  out  DATA_W  load data to MEM/WB readData_in, registered
- bus_err_o  out  1  one-cycle pulse on timeout
- misalign_o  out  1  one-cycle pulse on misaligned access; tied 0 without the macro

Behaviour:
- Reset is asynchronous and active-high; the clock is clk.
- Reset values: state = IDLE; dmem_req, dmem_we, bus_err_o and misalign_o = 0; dmem_addr, dmem_wdata and readData_o = 0; timeout counter = 0.
- Access condition: acc = valid_m & (memRead_m | memWrite_m).
- IDLE:
  - If acc: latch aluRes_m, writeData_m and memWrite_m into dmem_addr, dmem_wdata and dmem_we; set dmem_req = 1 at the edge; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - dmem_req, dmem_addr, dmem_we and dmem_wdata are held stable until ack.
  - Counter increments each cycle.
  - On dmem_ack: dmem_req = 0; for a load, readData_o <= dmem_rdata (for a store, readData_o holds its value); go to DONE.
  - If the counter reaches TIMEOUT_CYC-1 without ack: dmem_req = 0, readData_o <= 0, bus_err_o pulses 1 for one cycle, go to DONE.
  - Ack takes priority over timeout in the same cycle.
- DONE:
  - The instruction advances into MEM/WB at the end of this cycle.
  - Next state is always IDLE; a following access is therefore seen in IDLE one cycle later (no back-to-back overlap).
- stall_o is combinational: (state == IDLE & acc) | (state == ACCESS).
- bubble_o = stall_o.
- Minimum latency: a memory instruction occupies the MEM stage for 3 cycles (IDLE, ACCESS with immediate ack, DONE), i.e. 2 stall cycles. Each additional cycle before ack adds one stall cycle.
- Non-memory instructions pass through with 0 stall.
- dmem_ack is ignored in IDLE and DONE.
- Reset during ACCESS drops dmem_req immediately (asynchronously); the outstanding transaction is abandoned and any later ack is ignored.
- The counter is cleared on entry to ACCESS.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - An access in IDLE with aluRes_m[0] = 1 issues no dmem_req.
  - misalign_o pulses 1 for one cycle and readData_o <= 0.
  - State goes IDLE -> DONE, giving 1 stall cycle.
- Not defined:
  - misalign_o is tied to 0.
  - Odd addresses are passed to dmem unchanged and handled as a normal access.

Decomposition:
- lsu_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t.
  - Default constants for ADDR_W, DATA_W and TIMEOUT_CYC.
- One sub-module, lsu_timeout_ctr: 8-bit counter with clear, enable and an expired flag at TIMEOUT_CYC-1.

Test Plan:
- Load at 0x0040, ack in first ACCESS cycle with rdata 0xBEEF:
  - dmem_req is high for 1 cycle with we = 0 and addr = 0x0040.
  - stall_o and bubble_o are high for 2 cycles.
  - readData_o = 0xBEEF in DONE.
- Store 0x1234 to 0x0010, ack after 3 waits:
  - dmem_we = 1 and wdata = 0x1234, held stable over 4 ACCESS cycles.
  - 5 stall cycles.
  - readData_o unchanged.
- ALU instruction (valid_m = 1, no read/write): stall_o = 0 and dmem_req = 0 throughout.
- No ack, TIMEOUT_CYC = 8:
  - dmem_req drops after 8 ACCESS cycles.
  - bus_err_o pulses once and readData_o = 0.
  - A late ack in DONE or IDLE is ignored.
- Reset asserted mid-ACCESS:
  - dmem_req = 0 and stall_o = 0 immediately; state = IDLE.
  - A subsequent load completes normally.
- With LSU_ALIGN_CHECK_EN, load at 0x0041: no dmem_req, misalign_o pulses once, 1 stall cycle, readData_o = 0.
